// File: rtl/sram_controller_if.sv
// Requester-side bus of sram_controller: latched request fields plus registered readData and combinational ready.
// Backpressure: the master holds an enable until it sees ready, then drops it.
interface sram_controller_if;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        readEn;
    logic        writeEn;
    logic [31:0] readData;
    logic        ready;

    modport master (
        output address, writeData, readEn, writeEn,
        input  readData, ready
    );

    modport slave (
        input  address, writeData, readEn, writeEn,
        output readData, ready
    );
endinterface

// File: rtl/sram_controller.sv
// SRAM controller: one 32-bit access runs as a low and a high 16-bit phase. DONE is at cycle 2P+1 (P=2, or P=4 with SRAM_EXTRA_WAIT_EN).
// Backpressure: ready stays low from the request until DONE. Requests are sampled only in IDLE, so any enable still high at IDLE starts a new access.
module sram_controller (
    input  logic              clk,
    input  logic              rst,
    sram_controller_if.slave  bus,
    inout  wire  [15:0]       SRAM_DQ,
    output logic [17:0]       SRAM_ADDR,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);

`ifdef SRAM_EXTRA_WAIT_EN
    localparam int P = 4;
`else
    localparam int P = 2;
`endif
    localparam logic [1:0] LAST = 2'(P - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic        is_write_q;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [17:0] addr_q;
    logic        we_n_q;
    logic        oe_n_q;
    logic        cs_n_q;
    logic        dq_oe_q;
    logic [15:0] dq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            word_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            cs_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
            dq_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // writeEn wins over readEn when both are raised together
                    if (bus.readEn || bus.writeEn) begin
                        state_q    <= LOW;
                        cnt_q      <= '0;
                        is_write_q <= bus.writeEn;
                        word_q     <= bus.address[18:2];
                        wdata_q    <= bus.writeData;
                        addr_q     <= {bus.address[18:2], 1'b0};
                        we_n_q     <= ~bus.writeEn;
                        oe_n_q     <= bus.writeEn;
                        cs_n_q     <= 1'b0;
                        dq_oe_q    <= bus.writeEn;
                        dq_q       <= bus.writeData[15:0];
                    end
                end
                LOW: begin
                    if (cnt_q == LAST) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                        addr_q  <= {word_q, 1'b1};
                        dq_q    <= wdata_q[31:16];
                        if (!is_write_q) rdata_q[15:0] <= SRAM_DQ;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                HIGH: begin
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        cs_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                        if (!is_write_q) rdata_q[31:16] <= SRAM_DQ;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready    = ((state_q == IDLE) && !bus.readEn && !bus.writeEn) || (state_q == DONE);
    assign bus.readData = rdata_q;

    assign SRAM_DQ   = dq_oe_q ? dq_q : 16'bz;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = cs_n_q;
    assign SRAM_UB_N = cs_n_q;
    assign SRAM_LB_N = cs_n_q;

    // Only the word-select bits of the byte address reach the SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.address[31:19], bus.address[1:0]};

endmodule
